// File: rtl/axi2per_res_channel.sv
// Response channel of the AXI-to-peripheral bridge: turns single-cycle peripheral responses
// into registered AXI R and B beats, collecting write errors across a burst into one B.
module axi2per_res_channel #(
  parameter int unsigned PER_ID_WIDTH   = 5,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned AXI_ID_WIDTH   = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,

  input  logic                      per_master_r_valid_i,
  input  logic                      per_master_r_opc_i,
  input  logic [31:0]               per_master_r_rdata_i,

  input  logic                      trans_req_i,
  input  logic                      trans_we_i,
  input  logic [AXI_ID_WIDTH-1:0]   trans_id_i,
  input  logic [AXI_USER_WIDTH-1:0] trans_user_i,
  input  logic [AXI_ADDR_WIDTH-1:0] trans_add_i,
  input  logic                      trans_last_i,

  output logic                      busy_o,

  output logic                      axi_slave_r_valid_o,
  output logic [AXI_DATA_WIDTH-1:0] axi_slave_r_data_o,
  output logic [1:0]                axi_slave_r_resp_o,
  output logic                      axi_slave_r_last_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_slave_r_id_o,
  output logic [AXI_USER_WIDTH-1:0] axi_slave_r_user_o,
  input  logic                      axi_slave_r_ready_i,

  output logic                      axi_slave_b_valid_o,
  output logic [1:0]                axi_slave_b_resp_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_slave_b_id_o,
  output logic [AXI_USER_WIDTH-1:0] axi_slave_b_user_o,
  input  logic                      axi_slave_b_ready_i
);

  if (AXI_DATA_WIDTH != 64 || PER_ID_WIDTH < 1 || AXI_ADDR_WIDTH < 3) begin : g_bad_param
    $error("axi2per_res_channel: unsupported parameterisation");
  end

  typedef enum logic [1:0] {StIdle, StWaitPer, StSendR, StSendB} state_e;

  state_e                    state_q;
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic [AXI_USER_WIDTH-1:0] user_q;
  logic                      add2_q;
  logic                      last_q;
  logic                      we_q;
  logic                      err_q;
  logic [AXI_DATA_WIDTH-1:0] r_data_q;
  logic [1:0]                resp_q;

  // Only the 32-bit lane select is needed from the address.
  logic unused_add;
  assign unused_add = ^{trans_add_i[AXI_ADDR_WIDTH-1:3], trans_add_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      id_q     <= '0;
      user_q   <= '0;
      add2_q   <= 1'b0;
      last_q   <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      r_data_q <= '0;
      resp_q   <= 2'b00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (trans_req_i) begin
            id_q    <= trans_id_i;
            user_q  <= trans_user_i;
            add2_q  <= trans_add_i[2];
            last_q  <= trans_last_i;
            we_q    <= trans_we_i;
            state_q <= StWaitPer;
          end
        end
        StWaitPer: begin
          if (per_master_r_valid_i) begin
            if (!we_q) begin
              r_data_q <= add2_q ? {per_master_r_rdata_i, 32'h0} : {32'h0, per_master_r_rdata_i};
              resp_q   <= per_master_r_opc_i ? 2'b10 : 2'b00;
              state_q  <= StSendR;
            end else begin
              err_q <= err_q | per_master_r_opc_i;
              if (last_q) begin
                resp_q  <= (err_q | per_master_r_opc_i) ? 2'b10 : 2'b00;
                state_q <= StSendB;
              end else begin
                state_q <= StIdle;
              end
            end
          end
        end
        StSendR: begin
          if (axi_slave_r_ready_i) state_q <= StIdle;
        end
        StSendB: begin
          if (axi_slave_b_ready_i) begin
            err_q   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs are forced quiet while reset is held, not just after the reset edge.
  assign busy_o              = (state_q != StIdle) & ~rst_i;
  assign axi_slave_r_valid_o = (state_q == StSendR) & ~rst_i;
  assign axi_slave_b_valid_o = (state_q == StSendB) & ~rst_i;
  assign axi_slave_r_data_o  = rst_i ? '0 : r_data_q;
  assign axi_slave_r_resp_o  = rst_i ? 2'b00 : resp_q;
  assign axi_slave_r_last_o  = last_q & ~rst_i;
  assign axi_slave_r_id_o    = rst_i ? '0 : id_q;
  assign axi_slave_r_user_o  = rst_i ? '0 : user_q;
  assign axi_slave_b_resp_o  = rst_i ? 2'b00 : resp_q;
  assign axi_slave_b_id_o    = rst_i ? '0 : id_q;
  assign axi_slave_b_user_o  = rst_i ? '0 : user_q;

endmodule

// File: tb/tb_axi2per_res_channel.sv
// Directed and randomized-stream checks of axi2per_res_channel against hand-computed values.
module tb_axi2per_res_channel;

  logic        clk = 1'b0;
  logic        rst;
  logic        per_valid, per_opc;
  logic [31:0] per_rdata;
  logic        req, we, last;
  logic [2:0]  id;
  logic [5:0]  user;
  logic [31:0] add;
  logic        busy;
  logic        r_valid, r_last, r_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp, b_resp;
  logic [2:0]  r_id, b_id;
  logic [5:0]  r_user, b_user;
  logic        b_valid, b_ready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi2per_res_channel dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .per_master_r_valid_i(per_valid),
    .per_master_r_opc_i  (per_opc),
    .per_master_r_rdata_i(per_rdata),
    .trans_req_i         (req),
    .trans_we_i          (we),
    .trans_id_i          (id),
    .trans_user_i        (user),
    .trans_add_i         (add),
    .trans_last_i        (last),
    .busy_o              (busy),
    .axi_slave_r_valid_o (r_valid),
    .axi_slave_r_data_o  (r_data),
    .axi_slave_r_resp_o  (r_resp),
    .axi_slave_r_last_o  (r_last),
    .axi_slave_r_id_o    (r_id),
    .axi_slave_r_user_o  (r_user),
    .axi_slave_r_ready_i (r_ready),
    .axi_slave_b_valid_o (b_valid),
    .axi_slave_b_resp_o  (b_resp),
    .axi_slave_b_id_o    (b_id),
    .axi_slave_b_user_o  (b_user),
    .axi_slave_b_ready_i (b_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat: request cycle, then the peripheral response cycle.
  task automatic beat(input logic w, input logic l, input logic o, input logic [31:0] a,
                      input logic [2:0] i, input logic [31:0] rd);
    req = 1'b1; we = w; last = l; add = a; id = i; user = 6'h15;
    tick();
    req = 1'b0;
    per_valid = 1'b1; per_opc = o; per_rdata = rd;
    tick();
    per_valid = 1'b0;
  endtask

  task automatic burst4(input logic [3:0] opcs);
    for (int k = 0; k < 4; k++) begin
      beat(1'b1, k == 3, opcs[k], 32'h0, 3'd2, 32'h0);
      if (k < 3) check("b_valid_mid_burst", {63'b0, b_valid}, 64'd0);
    end
  endtask

  logic [63:0] snap_data, exp_data;
  logic [1:0]  snap_resp;
  logic        snap_rv, snap_bv, done, rw, rl, ro, ra;
  logic [31:0] rrd;
  int          n_resp, n_exp_resp;

  initial begin
    rst = 1'b1; per_valid = 1'b0; per_opc = 1'b0; per_rdata = '0;
    req = 1'b0; we = 1'b0; last = 1'b0; id = '0; user = '0; add = '0;
    r_ready = 1'b0; b_ready = 1'b0;
    tick(); tick();
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_r_valid", {63'b0, r_valid}, 64'd0);
    check("rst_b_valid", {63'b0, b_valid}, 64'd0);
    check("rst_r_data", r_data, 64'd0);
    rst = 1'b0;
    tick();

    // Read to upper lane, immediate ready.
    r_ready = 1'b1;
    req = 1'b1; we = 1'b0; last = 1'b1; add = 32'h1000_0004; id = 3'd3; user = 6'h2A;
    tick();
    req = 1'b0;
    check("wait_busy", {63'b0, busy}, 64'd1);
    check("wait_r_valid", {63'b0, r_valid}, 64'd0);
    per_valid = 1'b1; per_opc = 1'b0; per_rdata = 32'hDEADBEEF;
    tick();
    per_valid = 1'b0;
    check("rd_valid", {63'b0, r_valid}, 64'd1);
    check("rd_data", r_data, 64'hDEADBEEF_00000000);
    check("rd_resp", {62'b0, r_resp}, 64'd0);
    check("rd_id", {61'b0, r_id}, 64'd3);
    check("rd_user", {58'b0, r_user}, 64'h2A);
    check("rd_last", {63'b0, r_last}, 64'd1);
    check("rd_b_valid", {63'b0, b_valid}, 64'd0);
    tick();
    check("rd_done_valid", {63'b0, r_valid}, 64'd0);
    check("rd_done_busy", {63'b0, busy}, 64'd0);

    // Lower-lane error read held under backpressure; a request while busy is ignored.
    r_ready = 1'b0;
    beat(1'b0, 1'b0, 1'b1, 32'h0000_0010, 3'd5, 32'h12345678);
    req = 1'b1; id = 3'd1; we = 1'b1; last = 1'b1; add = 32'h4;
    for (int k = 0; k < 4; k++) begin
      check("hold_valid", {63'b0, r_valid}, 64'd1);
      check("hold_data", r_data, 64'h00000000_12345678);
      check("hold_resp", {62'b0, r_resp}, 64'd2);
      check("hold_id", {61'b0, r_id}, 64'd5);
      check("hold_last", {63'b0, r_last}, 64'd0);
      check("hold_busy", {63'b0, busy}, 64'd1);
      tick();
    end
    req = 1'b0;
    r_ready = 1'b1;
    tick();
    check("hold_done_busy", {63'b0, busy}, 64'd0);

    // Stray peripheral response in idle.
    per_valid = 1'b1; per_opc = 1'b1;
    tick();
    per_valid = 1'b0;
    check("stray_busy", {63'b0, busy}, 64'd0);
    check("stray_r_valid", {63'b0, r_valid}, 64'd0);
    check("stray_b_valid", {63'b0, b_valid}, 64'd0);

    // Write burst with an error on beat 2, then a clean burst.
    b_ready = 1'b0;
    burst4(4'b0010);
    check("wb_valid", {63'b0, b_valid}, 64'd1);
    check("wb_resp", {62'b0, b_resp}, 64'd2);
    check("wb_id", {61'b0, b_id}, 64'd2);
    check("wb_user", {58'b0, b_user}, 64'h15);
    check("wb_r_valid", {63'b0, r_valid}, 64'd0);
    tick();
    check("wb_hold_valid", {63'b0, b_valid}, 64'd1);
    b_ready = 1'b1;
    tick();
    check("wb_done_valid", {63'b0, b_valid}, 64'd0);
    burst4(4'b0000);
    check("wb2_valid", {63'b0, b_valid}, 64'd1);
    check("wb2_resp", {62'b0, b_resp}, 64'd0);
    tick();

    // Reset during SEND_B without handshake.
    b_ready = 1'b0;
    burst4(4'b0001);
    check("rstb_pre_valid", {63'b0, b_valid}, 64'd1);
    rst = 1'b1;
    #1;
    check("rstb_during_valid", {63'b0, b_valid}, 64'd0);
    tick();
    rst = 1'b0;
    check("rstb_busy", {63'b0, busy}, 64'd0);
    check("rstb_valid", {63'b0, b_valid}, 64'd0);
    b_ready = 1'b1;
    burst4(4'b0000);
    check("rstb_next_resp", {62'b0, b_resp}, 64'd0);
    tick();

    // Random stream with random ready backpressure.
    n_resp = 0; n_exp_resp = 0;
    for (int t = 0; t < 60; t++) begin
      rw = 1'($urandom); rl = 1'($urandom); ro = 1'($urandom); ra = 1'($urandom);
      rrd = $urandom;
      r_ready = 1'($urandom); b_ready = 1'($urandom);
      beat(rw, rl, ro, {29'b0, ra, 2'b0}, 3'(t), rrd);
      if (rw && !rl) begin
        check("rnd_no_b", {62'b0, r_valid, b_valid}, 64'd0);
        continue;
      end
      n_exp_resp++;
      exp_data = ra ? {rrd, 32'h0} : {32'h0, rrd};
      if (!rw) begin
        check("rnd_r_data", r_data, exp_data);
        check("rnd_r_resp", {62'b0, r_resp}, {62'b0, ro, 1'b0});
      end
      done = 1'b0;
      for (int c = 0; c < 12 && !done; c++) begin
        check("rnd_excl", {63'b0, r_valid & b_valid}, 64'd0);
        r_ready = (c > 8) ? 1'b1 : 1'($urandom);
        b_ready = (c > 8) ? 1'b1 : 1'($urandom);
        snap_rv = r_valid; snap_bv = b_valid;
        snap_data = r_data; snap_resp = rw ? b_resp : r_resp;
        if ((r_valid && r_ready) || (b_valid && b_ready)) begin
          n_resp++;
          done = 1'b1;
        end
        tick();
        if (!done) begin
          check("rnd_stable_valid", {62'b0, r_valid, b_valid}, {62'b0, snap_rv, snap_bv});
          check("rnd_stable_resp", {62'b0, rw ? b_resp : r_resp}, {62'b0, snap_resp});
          if (!rw) check("rnd_stable_data", r_data, snap_data);
        end
      end
      check("rnd_handshake", {63'b0, done}, 64'd1);
      check("rnd_idle", {63'b0, busy}, 64'd0);
    end
    check("rnd_resp_count", 64'(n_resp), 64'(n_exp_resp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
